mfp_pmod_spi_transmitter: RTL and testbench
===========================================

MFP_PMOD_SPI_TRANSMITTER -- requirements
Module: mfp_pmod_spi_transmitter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the number of bits shifted per frame (legal range 2..32).
REQ-002 Parameter HALF_PERIOD, default 4, SHALL set the SCK half-period in clock cycles (legal range 1..255).
REQ-003 Port clock, input, 1: SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1: SHALL be the asynchronous, active-low reset.
REQ-005 Port data, input, DATA_WIDTH: SHALL carry the word to transmit, sampled only on acceptance.
REQ-006 Port valid, input, 1: SHALL request transmission of data.
REQ-007 Port ready, output, 1: SHALL be high when a new word can be accepted.
REQ-008 Port busy, output, 1: SHALL be high from acceptance until ready rises again.
REQ-009 Port done, output, 1: SHALL pulse high for one cycle when cs deasserts at frame end.
REQ-010 Ports cs (1, active low), sck (1) and mosi (1), all outputs: SHALL be the SPI chip select, serial clock and serial data.

Function
REQ-011 Acceptance SHALL occur on a rising edge where valid=1 and ready=1; valid while ready=0 SHALL be ignored, with no queuing.
REQ-012 SPI mode 0: SCK idle low; mosi stable before each SCK rise; mosi changes only on the cycle SCK falls.
REQ-013 States: IDLE, SETUP, SHIFT, HOLD, GAP; all outputs registered (no combinational paths from inputs to outputs).
REQ-014 IDLE: ready=1, busy=0, cs=1, sck=0, mosi=0; acceptance -> SETUP.
REQ-015 Cycle-level timing, with edge E0 as acceptance and H=HALF_PERIOD:
- after E0: cs=0, mosi=data[MSB], ready=0, busy=1, sck=0
- after E0+(1+2k)H: sck=1, for bit k=0..DATA_WIDTH-1
- after E0+(2+2k)H: sck=0 and mosi=next bit (MSB first)
- after the last fall (E0+2*DATA_WIDTH*H): mosi=0; HOLD lasts H cycles
- after E0+(2*DATA_WIDTH+1)H: cs=1, done=1 for one cycle; GAP lasts H cycles
- after E0+(2*DATA_WIDTH+2)H: ready=1, busy=0, state IDLE.
REQ-016 The data word SHALL be latched into an internal shift register on acceptance; later changes to data SHALL NOT affect the frame in flight.
REQ-017 Exactly DATA_WIDTH SCK rising edges SHALL occur per frame; the bit counter SHALL NOT wrap or produce extra edges.
REQ-018 The half-period counter SHALL reload at each phase boundary; H=1 SHALL give SCK = clock/2 with no lost or stretched phases.
REQ-019 Back-to-back: valid held high SHALL start the next frame on the edge where ready=1, so cs is high for exactly H cycles between frames.

Reset
REQ-020 Asserting reset_n=0 at any time, including mid-frame, SHALL immediately force state=IDLE, cs=1, sck=0, mosi=0, done=0, busy=0, ready=1, and clear the counters and shift register.
REQ-021 After release, no partial frame SHALL resume; the first acceptance SHALL start at bit MSB.

Verification
REQ-022 DATA_WIDTH=16, H=4, data=16'hA5C3 pulse valid -> 16 SCK rises; mosi sampled at rises = 1010010111000011; cs low 132 cycles; done at E0+132; ready at E0+136.
REQ-023 H=1, data=16'hFFFF then 16'h0000, valid held high -> two frames with cs high exactly 1 cycle between; mosi all-1 then all-0; 2-cycle SCK period.
REQ-024 data changed to 16'h0000 at E0+10 during a frame of 16'h8001 -> shifted bits remain 1000000000000001.
REQ-025 reset_n low at E0+50 mid-frame -> same cycle cs=1, sck=0, mosi=0, ready=1; next valid with 16'h1234 transmits a full, correct frame.
REQ-026 valid pulsed while busy=1 -> ignored; exactly one frame observed; done pulses exactly once per frame.

Source files
------------

// File: rtl/mfp_pmod_spi_transmitter.sv
// SPI mode-0 serialiser: one DATA_WIDTH word per frame, MSB first, all outputs registered.
// A request waiting at the end of the inter-frame gap starts the next frame directly, so cs stays high exactly H cycles.
module mfp_pmod_spi_transmitter #(
  parameter int DATA_WIDTH  = 16,
  parameter int HALF_PERIOD = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  cs,
  output logic                  sck,
  output logic                  mosi
);

  localparam logic [7:0] H_LOAD   = 8'(HALF_PERIOD - 1);
  localparam logic [5:0] LAST_BIT = 6'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t                state, state_nxt;
  logic [7:0]            hp_cnt, hp_cnt_nxt;
  logic [5:0]            bit_cnt, bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic                  ready_nxt, busy_nxt, done_nxt, cs_nxt, sck_nxt, mosi_nxt;
  logic                  hp_end, start;

  assign hp_end = (hp_cnt == 8'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      hp_cnt  <= 8'd0;
      bit_cnt <= 6'd0;
      shreg   <= '0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      cs      <= 1'b1;
      sck     <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      state   <= state_nxt;
      hp_cnt  <= hp_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      ready   <= ready_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      cs      <= cs_nxt;
      sck     <= sck_nxt;
      mosi    <= mosi_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    hp_cnt_nxt  = hp_end ? H_LOAD : hp_cnt - 8'd1;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    ready_nxt   = ready;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    cs_nxt      = cs;
    sck_nxt     = sck;
    mosi_nxt    = mosi;
    start       = 1'b0;

    case (state)
      IDLE: begin
        hp_cnt_nxt = 8'd0;
        start      = valid && ready;
      end
      SETUP: begin
        if (hp_end) begin
          sck_nxt   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (hp_end) begin
          sck_nxt = ~sck;
          // mosi only moves on the falling phase, keeping it stable across each rise
          if (sck) begin
            if (bit_cnt == LAST_BIT) begin
              mosi_nxt  = 1'b0;
              state_nxt = HOLD;
            end else begin
              mosi_nxt    = shreg[DATA_WIDTH-1];
              shreg_nxt   = {shreg[DATA_WIDTH-2:0], 1'b0};
              bit_cnt_nxt = bit_cnt + 6'd1;
            end
          end
        end
      end
      HOLD: begin
        if (hp_end) begin
          cs_nxt    = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (hp_end) begin
          if (valid) begin
            start = 1'b1;
          end else begin
            ready_nxt = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
        busy_nxt  = 1'b0;
        cs_nxt    = 1'b1;
        sck_nxt   = 1'b0;
        mosi_nxt  = 1'b0;
      end
    endcase

    if (start) begin
      state_nxt   = SETUP;
      hp_cnt_nxt  = H_LOAD;
      bit_cnt_nxt = 6'd0;
      shreg_nxt   = {data[DATA_WIDTH-2:0], 1'b0};
      mosi_nxt    = data[DATA_WIDTH-1];
      cs_nxt      = 1'b0;
      sck_nxt     = 1'b0;
      ready_nxt   = 1'b0;
      busy_nxt    = 1'b1;
    end
  end

endmodule

// File: tb/tb_mfp_pmod_spi_transmitter.sv
// Randomised and directed frames checked cycle by cycle against an arithmetic timing model.
module tb_mfp_pmod_spi_transmitter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] data0 = '0, data1 = '0;
  logic        valid0 = 1'b0, valid1 = 1'b0;
  logic        ready0, busy0, done0, cs0, sck0, mosi0;
  logic        ready1, busy1, done1, cs1, sck1, mosi1;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  mfp_pmod_spi_transmitter #(.DATA_WIDTH(16), .HALF_PERIOD(4)) dut (
    .clock(clock), .reset_n(reset_n), .data(data0), .valid(valid0),
    .ready(ready0), .busy(busy0), .done(done0), .cs(cs0), .sck(sck0), .mosi(mosi0)
  );

  mfp_pmod_spi_transmitter #(.DATA_WIDTH(16), .HALF_PERIOD(1)) dut_fast (
    .clock(clock), .reset_n(reset_n), .data(data1), .valid(valid1),
    .ready(ready1), .busy(busy1), .done(done1), .cs(cs1), .sck(sck1), .mosi(mosi1)
  );

  // Expected {cs,sck,mosi,done,ready,busy} t cycles after the acceptance edge.
  function automatic logic [5:0] model(input logic [15:0] d, input int h, input int t);
    logic c, s, m, dn, r;
    int   fall_end;
    fall_end = 32 * h;
    c  = (t >= 33 * h);
    s  = (t < fall_end) && (((t / h) % 2) == 1);
    m  = (t < fall_end) ? d[15 - t / (2 * h)] : 1'b0;
    dn = (t == 33 * h);
    r  = (t >= 34 * h);
    return {c, s, m, dn, r, ~r};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One frame on the H=4 instance; optional data change, stray valid pulse, or reset at cycle offsets.
  task automatic run0(input logic [15:0] d, input int chg_at, input int pulse_at,
                      input int abort_at, input string tag);
    logic [15:0] got;
    logic        prev;
    int          rises, dones;
    got = '0; prev = 1'b0; rises = 0; dones = 0;
    data0 = d; valid0 = 1'b1;
    tick();
    valid0 = 1'b0;
    for (int t = 0; t <= 136; t++) begin
      if (t > 0) tick();
      check({tag, ":wave"}, 32'({cs0, sck0, mosi0, done0, ready0, busy0}), 32'(model(d, 4, t)));
      if (t == abort_at) begin
        reset_n = 1'b0;
        #1;
        check({tag, ":reset"}, 32'({cs0, sck0, mosi0, done0, ready0, busy0}), 32'(6'b100010));
        tick();
        reset_n = 1'b1;
        return;
      end
      if (sck0 && !prev) begin
        if (rises < 16) got[15 - rises] = mosi0;
        rises++;
      end
      prev  = sck0;
      dones += int'(done0);
      if (t == chg_at) data0 = 16'h0000;
      valid0 = (t == pulse_at);
    end
    check({tag, ":bits"}, 32'(got), 32'(d));
    check({tag, ":rises"}, 32'(rises), 32'd16);
    check({tag, ":dones"}, 32'(dones), 32'd1);
  endtask

  initial begin
    logic [31:0] bits_q [2];
    logic        prev;
    int          rises, cs_high, dones, f, tt;

    repeat (3) tick();
    check("reset0", 32'({cs0, sck0, mosi0, done0, ready0, busy0}), 32'(6'b100010));
    check("reset1", 32'({cs1, sck1, mosi1, done1, ready1, busy1}), 32'(6'b100010));
    reset_n = 1'b1;
    tick();

    run0(16'hA5C3, -1, -1, -1, "a5c3");
    run0(16'h8001, 10, -1, -1, "late_data");
    run0(16'($urandom), -1, 20, -1, "stray_valid");
    check("stray_idle", 32'({ready0, busy0, cs0}), 32'(3'b101));
    run0(16'($urandom), -1, -1, 50, "abort");
    run0(16'h1234, -1, -1, -1, "after_reset");
    repeat (5) run0(16'($urandom), -1, -1, -1, "random");

    // Back-to-back on the H=1 instance with valid held high.
    bits_q[0] = '0; bits_q[1] = '0;
    prev = 1'b0; rises = 0; cs_high = 0; dones = 0;
    data1 = 16'hFFFF; valid1 = 1'b1;
    tick();
    data1 = 16'h0000;
    for (int t = 0; t <= 68; t++) begin
      if (t > 0) tick();
      f  = (t >= 34) ? 1 : 0;
      tt = t - 34 * f;
      check("b2b:wave", 32'({cs1, sck1, mosi1, done1, ready1, busy1}),
            32'(model(f == 1 ? 16'h0000 : 16'hFFFF, 1, tt)));
      if (sck1 && !prev) begin
        if (rises < 32) bits_q[rises / 16][15 - rises % 16] = mosi1;
        rises++;
      end
      prev = sck1;
      if (t < 67 && cs1) cs_high++;
      dones += int'(done1);
      if (t == 34) valid1 = 1'b0;
    end
    check("b2b:bits0", bits_q[0], 32'h0000FFFF);
    check("b2b:bits1", bits_q[1], 32'h00000000);
    check("b2b:rises", 32'(rises), 32'd32);
    check("b2b:gap", 32'(cs_high), 32'd1);
    check("b2b:dones", 32'(dones), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
